// File: rtl/irq_ctrl_if.sv
// MIO register-window bus between the CPU side and the interrupt controller.
interface irq_ctrl_if;
    logic        sel;
    logic        we;
    logic [1:0]  reg_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output we, output reg_addr, output wdata, input rdata);
    modport slave  (input sel, input we, input reg_addr, input wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises and edge-detects sources into pending bits,
// masks them into a registered INT level, and exposes PEND/MASK/ACK/VEC registers.
module irq_ctrl #(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic [N_SRC-1:0] irq_in,
    irq_ctrl_if.slave        bus,
    output logic             INT
);

    logic [SYNC_STAGES-1:0][N_SRC-1:0] r_sync;
    logic [N_SRC-1:0] r_prev;
    logic [N_SRC-1:0] r_pend;
    logic [N_SRC-1:0] r_mask;
    logic [31:0]      r_rdata;
    logic             r_int;

    logic [N_SRC-1:0] w_s;
    logic [N_SRC-1:0] w_rise;
    logic [N_SRC-1:0] w_act;
    logic [N_SRC-1:0] w_ack_bits;
    logic [N_SRC-1:0] w_pend_d;
    logic             w_ack_wr;
    logic             w_mask_wr;
    logic             w_rd;
    logic [3:0]       w_idx;
    logic [31:0]      w_vec;
    logic [31:0]      w_rdata;
    logic             w_unused;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_s & ~r_prev;
    assign w_act     = r_pend & r_mask;
    assign w_ack_wr  = bus.sel & bus.we & (bus.reg_addr == 2'd2);
    assign w_mask_wr = bus.sel & bus.we & (bus.reg_addr == 2'd1);
    assign w_rd      = bus.sel & ~bus.we;

    assign w_ack_bits = w_ack_wr ? bus.wdata[N_SRC-1:0] : '0;
    // A rise on the same edge as its ACK keeps the bit pending.
    assign w_pend_d   = w_rise | (r_pend & ~w_ack_bits);

    assign w_unused = ^bus.wdata[31:N_SRC];

    // Scan high-to-low so the lowest active index wins.
    always_comb begin
        w_idx = 4'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_idx = 4'(i);
            end
        end
    end

    assign w_vec = {|w_act, 27'd0, w_idx};

    always_comb begin
        w_rdata = 32'd0;
        case (bus.reg_addr)
            2'd0:    w_rdata = 32'(r_pend);
            2'd1:    w_rdata = 32'(r_mask);
            2'd2:    w_rdata = 32'd0;
            default: w_rdata = w_vec;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            r_sync  <= '0;
            r_prev  <= '0;
            r_pend  <= '0;
            r_mask  <= '0;
            r_rdata <= '0;
            r_int   <= 1'b0;
        end else begin
            r_sync[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_prev <= w_s;
            r_pend <= w_pend_d;
            if (w_mask_wr) begin
                r_mask <= bus.wdata[N_SRC-1:0];
            end
            if (w_rd) begin
                r_rdata <= w_rdata;
            end
            r_int <= |w_act;
        end
    end

    assign bus.rdata = r_rdata;
    assign INT       = r_int;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (N_SRC=4, SYNC_STAGES=2).
module tb_irq_ctrl;

    logic       clk = 1'b0;
    logic       RSTN;
    logic [3:0] irq_in;
    logic       INT;
    int         checks = 0;
    int         errors = 0;

    irq_ctrl_if bus ();

    irq_ctrl #(.N_SRC(4), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .RSTN   (RSTN),
        .irq_in (irq_in),
        .bus    (bus.slave),
        .INT    (INT)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled at negedge, away from the active edge.
    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.sel = 1'b1; bus.we = 1'b1; bus.reg_addr = addr; bus.wdata = data;
        @(negedge clk);
        bus.sel = 1'b0; bus.we = 1'b0; bus.wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
        bus.sel = 1'b1; bus.we = 1'b0; bus.reg_addr = addr;
        @(negedge clk);
        data = bus.rdata;
        bus.sel = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        RSTN = 1'b0; irq_in = 4'hF;
        idle(2);
        checks++; if (bus.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want %h", bus.rdata, 32'd0); end
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL reset_int got %b want 0", INT); end
        RSTN = 1'b1;
        idle(5);
        irq_in = 4'h0;
        bus_read(2'd0, d);
        checks++; if (d !== 32'hF) begin errors++; $display("FAIL reset_pend got %h want %h", d, 32'hF); end
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL reset_int_masked got %b want 0", INT); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_vec_masked got %h want %h", d, 32'd0); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        bus_write(2'd0, 32'd0);
        bus_read(2'd0, d);
        checks++; if (d !== 32'hF) begin errors++; $display("FAIL pend_ro got %h want %h", d, 32'hF); end
        bus_write(2'd1, 32'hFFFF_FFF5);
        bus_read(2'd1, d);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL mask_rw got %h want %h", d, 32'h5); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL ack_read got %h want %h", d, 32'd0); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL vec_idx0 got %h want %h", d, 32'h8000_0000); end
        bus_write(2'd1, 32'd0);
    endtask

    task automatic test_latency();
        logic [31:0] d;
        bus_write(2'd2, 32'hF);
        bus_write(2'd1, 32'h4);
        idle(2);
        // Hold a PEND read open so rdata tracks pend one edge behind.
        bus.sel = 1'b1; bus.we = 1'b0; bus.reg_addr = 2'd0;
        irq_in = 4'h4;
        @(negedge clk); irq_in = 4'h0;
        @(negedge clk);
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL lat_int_e2 got %b want 0", INT); end
        @(negedge clk);
        checks++; if (bus.rdata !== 32'd0) begin errors++; $display("FAIL lat_pend_e3 got %h want %h", bus.rdata, 32'd0); end
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL lat_int_e3 got %b want 0", INT); end
        @(negedge clk);
        checks++; if (bus.rdata !== 32'h4) begin errors++; $display("FAIL lat_pend_e4 got %h want %h", bus.rdata, 32'h4); end
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL lat_int_e4 got %b want 1", INT); end
        bus.sel = 1'b0;
        bus_read(2'd3, d);
        checks++; if (d !== 32'h8000_0002) begin errors++; $display("FAIL lat_vec got %h want %h", d, 32'h8000_0002); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        bus_write(2'd2, 32'hF);
        bus_write(2'd1, 32'hA);
        irq_in = 4'hA;
        @(negedge clk); irq_in = 4'h0;
        idle(5);
        bus_read(2'd3, d);
        checks++; if (d !== 32'h8000_0001) begin errors++; $display("FAIL prio_vec1 got %h want %h", d, 32'h8000_0001); end
        bus_write(2'd2, 32'h2);
        bus_read(2'd3, d);
        checks++; if (d !== 32'h8000_0003) begin errors++; $display("FAIL prio_vec3 got %h want %h", d, 32'h8000_0003); end
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL prio_int_on got %b want 1", INT); end
        bus_write(2'd2, 32'h8);
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL prio_int_lag got %b want 1", INT); end
        @(negedge clk);
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL prio_int_off got %b want 0", INT); end
    endtask

    task automatic test_ack_race();
        logic [31:0] d;
        bus_write(2'd2, 32'hF);
        bus_write(2'd1, 32'h1);
        irq_in = 4'h1;
        @(negedge clk); irq_in = 4'h0;
        idle(5);
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL race_int_pre got %b want 1", INT); end
        irq_in = 4'h1;
        @(negedge clk); irq_in = 4'h0;
        @(negedge clk);
        // The ACK edge is the edge that captures the new rise.
        bus_write(2'd2, 32'h1);
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL race_int_e3 got %b want 1", INT); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL race_pend got %h want %h", d, 32'h1); end
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL race_int_post got %b want 1", INT); end
        bus_write(2'd2, 32'h1);
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL race_ack_clear got %h want %h", d, 32'h0); end
    endtask

    task automatic test_unmask();
        logic [31:0] d;
        bus_write(2'd1, 32'h0);
        bus_write(2'd2, 32'hF);
        irq_in = 4'h1;
        @(negedge clk); irq_in = 4'h0;
        idle(5);
        bus_read(2'd0, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL unmask_pend got %h want %h", d, 32'h1); end
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL unmask_int_masked got %b want 0", INT); end
        bus_write(2'd1, 32'h1);
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL unmask_int_lag got %b want 0", INT); end
        @(negedge clk);
        checks++; if (INT !== 1'b1) begin errors++; $display("FAIL unmask_int_on got %b want 1", INT); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] d;
        RSTN = 1'b0;
        @(negedge clk);
        RSTN = 1'b1;
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL mreset_int got %b want 0", INT); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mreset_pend got %h want %h", d, 32'h0); end
        bus_read(2'd1, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mreset_mask got %h want %h", d, 32'h0); end
        bus_write(2'd1, 32'hF);
        idle(6);
        checks++; if (INT !== 1'b0) begin errors++; $display("FAIL mreset_spurious got %b want 0", INT); end
    endtask

    initial begin
        RSTN = 1'b0; irq_in = 4'h0;
        bus.sel = 1'b0; bus.we = 1'b0; bus.reg_addr = 2'd0; bus.wdata = 32'd0;
        @(negedge clk);
        test_reset();
        test_regs();
        test_latency();
        test_priority();
        test_ack_race();
        test_unmask();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
